// File: rtl/regfile_write_arbiter.sv
// Purpose : round-robin arbiter that shares the single register-file write port among N_REQ writeback sources.
// Latency : req_ready is combinational in the request cycle; load_en/wr_data/grant_id/wr_fire are registered one cycle after the handshake.
// Backpressure: a request stalls (req_ready=0) while another requester wins, while hold=1, or while reset=1; the request must stay stable until it is granted.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   hold              suppresses any grant in the current cycle
//   req_valid         per-requester write request
//   req_addr          packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data          packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         combinational one-hot grant
//   load_en           registered one-hot load enables, one per register
//   wr_data           registered write data shared by all registers
//   grant_id          registered index of the last winner
//   wr_fire           registered strobe, 1 in the cycle after any grant
//
// Build option: REGFILE_ZERO_REG_EN makes register 0 hardwired zero. A write to
// address 0 still handshakes and fires, but load_en stays all-zero.

module regfile_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            hold,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]                req_ready,
    output logic [(1<<ADDR_WIDTH)-1:0]      load_en,
    output logic [DATA_WIDTH-1:0]           wr_data,
    output logic [$clog2(N_REQ)-1:0]        grant_id,
    output logic                            wr_fire
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int N_REG = 1 << ADDR_WIDTH;

    // Registered write command that drives the register file.
    typedef struct packed {
        logic [N_REG-1:0]      load_en;
        logic [DATA_WIDTH-1:0] data;
        logic [ID_W-1:0]       id;
        logic                  fire;
    } wr_cmd_t;

    wr_cmd_t         cmd_q;
    wr_cmd_t         cmd_d;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_d;

    logic            grant_any;
    logic [ID_W-1:0] grant_idx;

    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [N_REG-1:0]      dec;

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating-priority search starting at rr_ptr. The candidate index is
    // wrapped by subtraction, so it stays below N_REQ even when N_REQ is not
    // a power of two.
    always_comb begin : arb
        int              cand;
        logic [ID_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[ID_W-1:0];
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        // Reset also blocks the grant so that no handshake can complete
        // while the block is being cleared.
        if (reset || hold) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    // Address decode into the per-register load enables.
    always_comb begin
        dec           = '0;
        dec[sel_addr] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
        // Register 0 reads as zero: the write is accepted but never loaded.
        if (sel_addr == '0) begin
            dec = '0;
        end
`else
`endif
    end

    // Next registered command and pointer. Without a grant the data and id
    // are held, and only the strobes drop.
    always_comb begin
        cmd_d         = cmd_q;
        cmd_d.load_en = '0;
        cmd_d.fire    = 1'b0;
        ptr_d         = rr_ptr;
        if (grant_any) begin
            cmd_d.load_en = dec;
            cmd_d.data    = sel_data;
            cmd_d.id      = grant_idx;
            cmd_d.fire    = 1'b1;
            ptr_d         = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q  <= '0;
            rr_ptr <= '0;
        end else begin
            cmd_q  <= cmd_d;
            rr_ptr <= ptr_d;
        end
    end

    assign load_en  = cmd_q.load_en;
    assign wr_data  = cmd_q.data;
    assign grant_id = cmd_q.id;
    assign wr_fire  = cmd_q.fire;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : self-checking bench for regfile_write_arbiter (N_REQ=4, DATA_WIDTH=8, ADDR_WIDTH=3).
// Latency : each stimulus cycle checks req_ready before the edge and the registered outputs #1 after it.
// Backpressure: random requesters keep their request stable until granted, and may occasionally drop it.

module tb_regfile_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NG = 1 << AW;

    logic              clock = 1'b0;
    logic              reset;
    logic              hold;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NG-1:0]     load_en;
    logic [DW-1:0]     wr_data;
    logic [1:0]        grant_id;
    logic              wr_fire;

    regfile_write_arbiter #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .load_en   (load_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .wr_fire   (wr_fire)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_ptr = 0;
    logic [7:0]  m_load = '0;
    logic [7:0]  m_wd = '0;
    int          m_gid = 0;
    logic        m_fire = 1'b0;
    logic [7:0]  m_mem [NG];
    // Register file built from the DUT's load_en / wr_data
    logic [7:0]  tb_mem [NG];
    logic [3:0]  last_ready;

    typedef struct {
        logic        rst;
        logic        hld;
        logic [3:0]  v;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  e_ready;
        logic [7:0]  e_load;
        logic [7:0]  e_wd;
        logic [1:0]  e_gid;
        logic        e_fire;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic hld, input logic [3:0] v,
                                input logic [11:0] a, input logic [31:0] d, input logic [3:0] er,
                                input logic [7:0] el, input logic [7:0] ew, input logic [1:0] eg,
                                input logic ef);
        vec_t r;
        r.rst = rst; r.hld = hld; r.v = v; r.a = a; r.d = d;
        r.e_ready = er; r.e_load = el; r.e_wd = ew; r.e_gid = eg; r.e_fire = ef;
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check req_ready, step the
    // model, then check the registered outputs just after the rising edge.
    task automatic run_cycle(input logic r, input logic h, input logic [3:0] v,
                             input logic [11:0] a, input logic [31:0] d, input bit chk);
        int         g;
        int         idx;
        logic [2:0] wa;
        logic [3:0] er;
        reset = r; hold = h; req_valid = v; req_addr = a; req_data = d;
        #1;
        g  = -1;
        er = '0;
        if (!r && !h) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        last_ready = req_ready;
        if (chk) check("req_ready", 32'(req_ready), 32'(er));
        if (r) begin
            m_ptr = 0; m_load = '0; m_wd = '0; m_gid = 0; m_fire = 1'b0;
        end else if (g >= 0) begin
            wa     = a[g*AW +: AW];
            m_wd   = d[g*DW +: DW];
            m_gid  = g;
            m_fire = 1'b1;
            m_ptr  = (g + 1) % NR;
            m_load = 8'd1 << wa;
`ifdef REGFILE_ZERO_REG_EN
            if (wa == 3'd0) m_load = '0;
            else m_mem[wa] = m_wd;
`else
            m_mem[wa] = m_wd;
`endif
        end else begin
            m_load = '0; m_fire = 1'b0;
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NG; i++) if (load_en[i]) tb_mem[i] = wr_data;
        if (chk) begin
            check("load_en",  32'(load_en),  32'(m_load));
            check("wr_data",  32'(wr_data),  32'(m_wd));
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("wr_fire",  32'(wr_fire),  32'(m_fire));
        end
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rv;
        logic [2:0]  ra [NR];
        logic [7:0]  rd [NR];
        logic [11:0] a;
        logic [31:0] d;
        logic        rr, rh;

        for (int i = 0; i < NG; i++) begin m_mem[i] = '0; tb_mem[i] = '0; end
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        rv = '0;
        for (int i = 0; i < NR; i++) begin ra[i] = '0; rd[i] = '0; end
        @(negedge clock);

        // ---------------- table-driven vectors ----------------
        //            rst   hold  valid  addr     data          ready  load   wd     gid   fire
        tbl[0]  = mk(1'b1, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 4'h4, 12'h140, 32'h00A50000, 4'h4, 8'h20, 8'hA5, 2'd2, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 4'h0, 12'h140, 32'h00A50000, 4'h0, 8'h00, 8'hA5, 2'd2, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h8, 8'h40, 8'h43, 2'd3, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h1, 8'h02, 8'h10, 2'd0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h2, 8'h04, 8'h21, 2'd1, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 4'hF, 12'hCD1, 32'h43322110, 4'h0, 8'h00, 8'h21, 2'd1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h4, 8'h08, 8'h32, 2'd2, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 4'h3, 12'hCD1, 32'h43322110, 4'h1, 8'h02, 8'h10, 2'd0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 4'h1, 12'hCD1, 32'h43322110, 4'h1, 8'h02, 8'h10, 2'd0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 4'hF, 12'hCD1, 32'h43322110, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 4'h2, 12'hCD1, 32'h43322110, 4'h2, 8'h04, 8'h21, 2'd1, 1'b1);

        for (int i = 0; i < 13; i++) begin
            run_cycle(tbl[i].rst, tbl[i].hld, tbl[i].v, tbl[i].a, tbl[i].d, 1'b0);
            check($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_load",  i), 32'(load_en),    32'(tbl[i].e_load));
            check($sformatf("tbl%0d_wd",    i), 32'(wr_data),    32'(tbl[i].e_wd));
            check($sformatf("tbl%0d_gid",   i), 32'(grant_id),   32'(tbl[i].e_gid));
            check($sformatf("tbl%0d_fire",  i), 32'(wr_fire),    32'(tbl[i].e_fire));
        end

        // ---------------- round-robin fairness ----------------
        run_cycle(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b0, 1'b0, 4'hF, 12'h8D1, 32'h44332211, 1'b1);
            check("rr_grant",  32'(grant_id), 32'(c % 4));
            check("rr_onehot", 32'($countones(load_en)), 32'd1);
        end

        // ---------------- hold ----------------
        run_cycle(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        run_cycle(1'b0, 1'b0, 4'h1, 12'h0D1, 32'h00332211, 1'b1);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b0, 1'b1, 4'h6, 12'h0D1, 32'h00332211, 1'b1);
            check("hold_ready", 32'(last_ready), 32'd0);
            check("hold_load",  32'(load_en),    32'd0);
        end
        run_cycle(1'b0, 1'b0, 4'h6, 12'h0D1, 32'h00332211, 1'b1);
        check("hold_first", 32'(grant_id), 32'd1);
        run_cycle(1'b0, 1'b0, 4'h4, 12'h0D1, 32'h00332211, 1'b1);
        check("hold_second", 32'(grant_id), 32'd2);

        // ---------------- same-address collision ----------------
        run_cycle(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        run_cycle(1'b0, 1'b0, 4'h4, 12'h844, 32'h33000011, 1'b1);
        run_cycle(1'b0, 1'b0, 4'h9, 12'h844, 32'h33000011, 1'b1);
        check("coll_first", 32'(wr_data), 32'h33);
        run_cycle(1'b0, 1'b0, 4'h1, 12'h844, 32'h33000011, 1'b1);
        check("coll_second", 32'(wr_data), 32'h11);
        check("coll_reg4", 32'(tb_mem[4]), 32'h11);

        // ---------------- register 0 ----------------
        run_cycle(1'b0, 1'b0, 4'h2, 12'h000, 32'h0000FF00, 1'b1);
        check("zero_ready", 32'(last_ready), 32'h2);
`ifdef REGFILE_ZERO_REG_EN
        check("zero_load", 32'(load_en), 32'h00);
`else
        check("zero_load", 32'(load_en), 32'h01);
`endif
        check("zero_fire", 32'(wr_fire), 32'd1);

        // ---------------- randomized against the model ----------------
        run_cycle(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] || $urandom_range(0, 7) == 0) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra[i] = 3'($urandom_range(0, 7));
                    rd[i] = 8'($urandom_range(0, 255));
                end
            end
            for (int i = 0; i < NR; i++) begin
                a[i*AW +: AW] = ra[i];
                d[i*DW +: DW] = rd[i];
            end
            rr = ($urandom_range(0, 39) == 0);
            rh = ($urandom_range(0, 5) == 0);
            run_cycle(rr, rh, rv, a, d, 1'b1);
            for (int i = 0; i < NR; i++) if (last_ready[i]) rv[i] = 1'b0;
        end
        for (int i = 0; i < NG; i++) check($sformatf("regfile%0d", i), 32'(tb_mem[i]), 32'(m_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between N_REQ requesters, for example the ALU writeback, the load unit and the debug port.
- Uses a rotating-priority (round-robin) scheme.
- Converts the winning request into a registered one-hot load-enable vector, plus write data, that drives the per-register load inputs of the register file.
- Sits between the pipeline writeback sources and the register file.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, register data width; matches register width n.
- ADDR_WIDTH, 3, register address width; the register file holds 2**ADDR_WIDTH registers.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  when 1, no grant is issued this cycle.
- req_valid  input  N_REQ  per-requester write request.
- req_addr  input  N_REQ*ADDR_WIDTH  packed destination addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  N_REQ*DATA_WIDTH  packed write data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_REQ  combinational one-hot grant; the transfer completes when req_valid[i] and req_ready[i] are both 1.
- load_en  output  2**ADDR_WIDTH  registered one-hot load enables, one per register.
- wr_data  output  DATA_WIDTH  registered write data, shared by all registers.
- grant_id  output  clog2(N_REQ)  registered index of the last winner.
- wr_fire  output  1  registered; 1 in the cycle load_en is nonzero or a write is suppressed.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - rr_ptr=0, load_en=0, wr_data=0, grant_id=0, wr_fire=0.
  - While reset=1, req_ready=0 combinationally, so no handshake can complete.
- Arbitration is combinational within a cycle:
  - Search req_valid starting at index rr_ptr, ascending and wrapping modulo N_REQ.
  - The first valid index g wins, and req_ready[g]=1. All other req_ready bits are 0.
  - No valid requests, or hold=1, gives req_ready=0.
- Registered on the edge after a grant (latency 1 cycle from handshake to load):
  - load_en is one-hot at req_addr[g].
  - wr_data=req_data[g], grant_id=g, wr_fire=1.
  - rr_ptr=(g+1) mod N_REQ.
- Cycle without a grant:
  - load_en=0 and wr_fire=0.
  - wr_data and grant_id hold their previous values.
  - rr_ptr is unchanged.
- Requesters must hold valid, addr and data stable until ready. Dropping valid before ready is legal and loses the request.
- Back-to-back grants are allowed every cycle, giving throughput 1 write/cycle.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once per N_REQ cycles, in order rr_ptr, rr_ptr+1, ...
- Same-address requests from different requesters are not merged. They are serialized in grant order, so the last granted write wins.
- hold=1 with valid requests: no grant and rr_ptr unchanged. Arbitration resumes from the same rr_ptr on the first cycle with hold=0.
- Reset asserted in the cycle after a grant: the pending load is discarded, and the next outputs are the reset values (load_en=0).
- rr_ptr wrap: for N_REQ not a power of two, rr_ptr never takes a value >= N_REQ.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined, register 0 is hardwired zero:
  - A granted request with addr 0 still completes its handshake and advances rr_ptr.
  - The registered load_en is all-zero; wr_fire=1, grant_id=g.
  - load_en[0] is never asserted.
- When undefined, addr 0 is an ordinary register and load_en[0] is asserted normally.

Test Plan:
- Reset: assert reset 2 cycles with req_valid=4'b1111 -> req_ready=0 throughout; load_en=0, wr_data=0, grant_id=0, wr_fire=0 after the edge.
- Single request: req_valid=4'b0100, addr2=5, data2=8'hA5 -> req_ready=4'b0100 the same cycle. Next cycle: load_en=8'b0010_0000, wr_data=8'hA5, grant_id=2, wr_fire=1; rr_ptr becomes 3.
- Round-robin: all four valid for 8 cycles from rr_ptr=0, each with a distinct addr -> grant_id sequence 0,1,2,3,0,1,2,3, one load per cycle.
- Hold: rr_ptr=1, req_valid=4'b0110, hold=1 for 3 cycles -> req_ready=0 and load_en=0. Release hold -> requester 1 is granted first, then requester 2.
- Collision: requesters 0 and 3 both target addr 4, data 8'h11 and 8'h33, rr_ptr=3 -> 8'h33 loads first, then 8'h11. Final reg4 contents = 8'h11.
- Zero register: with REGFILE_ZERO_REG_EN, requester 1 addr 0 data 8'hFF -> req_ready[1]=1, next cycle load_en=0, wr_fire=1. Without the macro -> load_en=8'b0000_0001.
